// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access-size codes,
// FSM state encoding and the byte-lane mask helper.
// No ports; imported by data_mem_ctrl and the bench.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Byte lanes touched by an access of 'size' starting at byte 'lane'.
  // Only meaningful for aligned accesses; misaligned ones never write.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// Request side: valid/ready, we, byte addr, size, unsigned, right-aligned wdata.
// Response side: valid/ready, extended rdata, err. master = requester, slave = controller.
interface data_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH_WORDS x 32 storage with per-byte write enables and a registered read.
// Ports: clk_i-free (clk), addr_i word index, we_i/be_i/wdata_i write, re_i/rdata_o read.
// Latency: write and read both take effect on the edge they are enabled; no backpressure.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Storage is deliberately never reset; the read register holds its value
  // until the next read so the controller can present it for as long as needed.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Serialising byte/half/word load-store controller in front of dmem_bank.
// Ports: clk, rst (sync, active-high), bus (slave modport of data_mem_ctrl_if).
// Latency: response valid LATENCY cycles after acceptance; one request in flight,
// req_ready only in IDLE, response held stable until resp_ready.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;

  logic        accept;
  logic        misalign;
  logic        req_err;
  logic [31:0] bank_rdata;
  logic [15:0] sel;
  logic [31:0] ext;

  assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign req_err  = misalign || (bus.req_addr >= ADDR_LIMIT) || (bus.req_size == SZ_ILL);
  assign accept   = bus.req_valid && bus.req_ready;

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk     (clk),
    .addr_i  (bus.req_addr[AW+1:2]),
    .we_i    (accept && bus.req_we && !req_err),
    .be_i    (lane_mask(bus.req_size, bus.req_addr[1:0])),
    .wdata_i (bus.req_wdata << {bus.req_addr[1:0], 3'b000}),
    .re_i    (accept && !bus.req_we && !req_err),
    .rdata_o (bank_rdata)
  );

  // Counter is loaded with LATENCY-1 on acceptance and WAIT leaves on the edge
  // where it decrements to 0, which puts resp_valid exactly LATENCY cycles out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_INIT;
          err_d   = req_err;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          size_d  = bus.req_size;
          lane_d  = bus.req_addr[1:0];
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
    end
  end

  // Lane select and extension work off captured request fields and the bank's
  // holding register, so the response stays stable for the whole RESP stay.
  assign sel = 16'(bank_rdata >> {lane_q, 3'b000});

  always_comb begin
    ext = bank_rdata;
    case (size_q)
      SZ_BYTE: ext = uns_q ? {24'b0, sel[7:0]}  : {{24{sel[7]}}, sel[7:0]};
      SZ_HALF: ext = uns_q ? {16'b0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
      default: ext = bank_rdata;
    endcase
  end

  // Outputs are also gated by rst so they read as idle during the reset cycle itself.
  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = (state_q == RESP) && !rst;
  assign bus.resp_err   = (state_q == RESP) && !rst && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !rst && !err_q && !we_q) ? ext : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: main instance at LATENCY=2 plus LATENCY=1
// and LATENCY=15 instances for latency checks. Expected values are hand-computed.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_x = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = SZ_WORD;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if bus();
  data_mem_ctrl_if bus1();
  data_mem_ctrl_if bus15();

  assign bus.req_valid     = req_valid;
  assign bus.req_we        = req_we;
  assign bus.req_addr      = req_addr;
  assign bus.req_size      = req_size;
  assign bus.req_unsigned  = req_unsigned;
  assign bus.req_wdata     = req_wdata;
  assign bus.resp_ready    = resp_ready;

  assign bus1.req_valid    = req_valid_x;
  assign bus1.req_we       = req_we;
  assign bus1.req_addr     = req_addr;
  assign bus1.req_size     = req_size;
  assign bus1.req_unsigned = req_unsigned;
  assign bus1.req_wdata    = req_wdata;
  assign bus1.resp_ready   = resp_ready;

  assign bus15.req_valid    = req_valid_x;
  assign bus15.req_we       = req_we;
  assign bus15.req_addr     = req_addr;
  assign bus15.req_size     = req_size;
  assign bus15.req_unsigned = req_unsigned;
  assign bus15.req_wdata    = req_wdata;
  assign bus15.resp_ready   = resp_ready;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2))  u_dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(15)) u_dut15 (.clk(clk), .rst(rst), .bus(bus15.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with the main DUT idle. lat = cycles from the
  // accepting edge to the first cycle with resp_valid (1 = next cycle).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // Same request to the LATENCY=1 and LATENCY=15 instances in lockstep.
  task automatic lat_pair(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output int l1, output int l15,
                          output logic [31:0] d1, output logic [31:0] d15);
    req_we = we; req_addr = addr; req_size = SZ_WORD; req_unsigned = 1'b0; req_wdata = wd;
    req_valid_x = 1'b1;
    resp_ready  = 1'b1;
    @(posedge clk); #1;
    req_valid_x = 1'b0;
    l1 = -1; l15 = -1; d1 = '0; d15 = '0;
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (bus1.resp_valid && l1 < 0) begin l1 = n; d1 = bus1.resp_rdata; end
      if (bus15.resp_valid && l15 < 0) begin l15 = n; d15 = bus15.resp_rdata; end
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r, d1, d15;
    logic        e;
    int          l, l1, l15, seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready",  bus.req_ready, 0);
    chk("rst resp_valid", bus.resp_valid, 0);
    chk("rst resp_err",   bus.resp_err, 0);
    chk("rst resp_rdata", bus.resp_rdata, 0);
    rst = 1'b0;
    #1;
    chk("rst release req_ready", bus.req_ready, 1);

    // Word store / load
    do_req(1, 32'h10, SZ_WORD, 0, 32'hDEADBEEF, r, e, l);
    chk("st_w lat", l, 2); chk("st_w err", e, 0); chk("st_w rdata", r, 0);
    do_req(0, 32'h10, SZ_WORD, 0, 32'h0, r, e, l);
    chk("ld_w lat", l, 2); chk("ld_w err", e, 0); chk("ld_w rdata", r, 32'hDEADBEEF);

    // Byte store and sub-word loads with both extensions
    do_req(1, 32'h12, SZ_BYTE, 0, 32'h0000007F, r, e, l);
    chk("st_b err", e, 0);
    do_req(0, 32'h13, SZ_BYTE, 0, 32'h0, r, e, l);
    chk("ld_b13 s", r, 32'hFFFFFFDE);
    do_req(0, 32'h12, SZ_HALF, 1, 32'h0, r, e, l);
    chk("ld_h12 u", r, 32'h0000DE7F);
    do_req(0, 32'h13, SZ_BYTE, 1, 32'h0, r, e, l);
    chk("ld_b13 u", r, 32'h000000DE);
    do_req(0, 32'h12, SZ_HALF, 0, 32'h0, r, e, l);
    chk("ld_h12 s", r, 32'hFFFFDE7F);
    do_req(0, 32'h11, SZ_BYTE, 0, 32'h0, r, e, l);
    chk("ld_b11 s", r, 32'hFFFFFFBE);
    do_req(0, 32'h10, SZ_BYTE, 1, 32'h0, r, e, l);
    chk("ld_b10 u", r, 32'h000000EF);

    // Error cases must respond with err and zero data and leave storage alone
    do_req(1, 32'h14, SZ_WORD, 0, 32'hCAFEF00D, r, e, l);
    chk("st_w14 err", e, 0);
    do_req(0, 32'h11, SZ_HALF, 0, 32'h0, r, e, l);
    chk("mis_h err", e, 1); chk("mis_h rdata", r, 0); chk("mis_h lat", l, 2);
    do_req(1, 32'h16, SZ_WORD, 0, 32'h11111111, r, e, l);
    chk("mis_w err", e, 1); chk("mis_w rdata", r, 0);
    do_req(0, 32'h1000, SZ_WORD, 0, 32'h0, r, e, l);
    chk("oor err", e, 1); chk("oor rdata", r, 0);
    do_req(1, 32'h14, SZ_ILL, 0, 32'h22222222, r, e, l);
    chk("ill err", e, 1); chk("ill rdata", r, 0);
    do_req(0, 32'h14, SZ_WORD, 0, 32'h0, r, e, l);
    chk("w14 unchanged", r, 32'hCAFEF00D); chk("w14 err", e, 0);

    // Half store into upper lanes, last legal word
    do_req(1, 32'h16, SZ_HALF, 0, 32'h0000BEEF, r, e, l);
    chk("st_h16 err", e, 0);
    do_req(0, 32'h14, SZ_WORD, 0, 32'h0, r, e, l);
    chk("w14 after half", r, 32'hBEEFF00D);
    do_req(1, 32'hFFC, SZ_WORD, 0, 32'hA5A55A5A, r, e, l);
    chk("st_last err", e, 0);
    do_req(0, 32'hFFC, SZ_WORD, 0, 32'h0, r, e, l);
    chk("ld_last rdata", r, 32'hA5A55A5A); chk("ld_last err", e, 0);

    // Response held under backpressure
    req_we = 1'b0; req_addr = 32'h10; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    l = 1;
    while (!bus.resp_valid && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
    chk("hold lat", l, 2);
    for (int i = 0; i < 5; i++) begin
      chk("hold valid", bus.resp_valid, 1);
      chk("hold rdata", bus.resp_rdata, 32'hDE7FBEEF);
      chk("hold req_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("release valid", bus.resp_valid, 0);
    chk("release req_ready", bus.req_ready, 1);

    // Reset during WAIT drops the response but keeps the committed store
    req_we = 1'b1; req_addr = 32'h20; req_size = SZ_WORD; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait no valid", bus.resp_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("inrst req_ready", bus.req_ready, 0);
    chk("inrst valid", bus.resp_valid, 0);
    rst = 1'b0;
    #1;
    chk("postrst req_ready", bus.req_ready, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    chk("dropped resp", seen, 0);
    do_req(0, 32'h20, SZ_WORD, 0, 32'h0, r, e, l);
    chk("ld_20 rdata", r, 32'h12345678); chk("ld_20 err", e, 0);

    // Latency 1 and 15
    lat_pair(1, 32'h10, 32'hDEADBEEF, l1, l15, d1, d15);
    chk("L1 st lat", l1, 1); chk("L15 st lat", l15, 15);
    lat_pair(0, 32'h10, 32'h0, l1, l15, d1, d15);
    chk("L1 ld lat", l1, 1); chk("L15 ld lat", l15, 15);
    chk("L1 ld rdata", d1, 32'hDEADBEEF); chk("L15 ld rdata", d15, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words, power of two, minimum 4.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid, range 1..15.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port req_valid  input  1: request present.
REQ-006 Port req_ready  output  1: controller can accept a request this cycle.
REQ-007 Port req_we  input  1: 1 = store, 0 = load.
REQ-008 Port req_addr  input  32: byte address.
REQ-009 Port req_size  input  2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 Port req_unsigned  input  1: load extension; 1 = zero-extend, 0 = sign-extend; ignored for word accesses and stores.
REQ-011 Port req_wdata  input  32: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
REQ-012 Port resp_valid  output  1: response present.
REQ-013 Port resp_ready  input  1: consumer accepts the response.
REQ-014 Port resp_rdata  output  32: extended load data; 0 for stores and errors.
REQ-015 Port resp_err  output  1: request was misaligned, out of range or illegal size.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; the accepting edge SHALL move the FSM IDLE->WAIT and load a latency counter with LATENCY-1.
REQ-018 If LATENCY=1, acceptance SHALL move the FSM directly to RESP.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter equals 0, so that resp_valid rises exactly LATENCY cycles after acceptance.
REQ-020 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL stay stable until an edge with resp_ready=1, which SHALL return the FSM to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-021 Storage SHALL be little-endian; word index = req_addr[log2(DEPTH_WORDS)+1:2]; the byte lane = req_addr[1:0].
REQ-022 Alignment rule: half accesses SHALL require addr[0]=0 and word accesses SHALL require addr[1:0]=00.
REQ-023 Error rule: an access SHALL be an error if it is misaligned, if req_addr >= 4*DEPTH_WORDS, or if req_size=11.
REQ-024 An erroneous request SHALL still complete the handshake with resp_err=1 and resp_rdata=0, and SHALL NOT modify storage.
REQ-025 Stores SHALL commit on the accepting edge, writing only the addressed byte lanes (one lane for byte, two for half, four for word); other lanes SHALL be unchanged.
REQ-026 Loads SHALL read storage on the accepting edge into a holding register.
REQ-027 For loads, extension SHALL be applied to select the lane and sign- or zero-extend it to 32 bits.
REQ-028 Because requests are serialised, a load following a store SHALL return the stored data.

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE, the counter SHALL clear, and resp_valid, resp_err and resp_rdata SHALL be 0; req_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-030 Reset SHALL NOT clear storage contents.
REQ-031 A transaction in flight when reset asserts SHALL be dropped with no response; a store already committed SHALL remain in storage.

Structure
REQ-032 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state typedef.
REQ-033 Sub-module dmem_bank SHALL hold the storage: a DEPTH_WORDS x 32 array with a 4-bit byte-write-enable, a synchronous write and a synchronous read.
REQ-034 Lane select, alignment check and extension SHALL live in data_mem_ctrl.

Verification
REQ-035 Word store 0xDEADBEEF @0x10, then word load @0x10, LATENCY=2 -> resp_valid exactly 2 cycles after each acceptance; rdata=0xDEADBEEF; err=0.
REQ-036 After REQ-035, byte store 0x7F @0x12, then byte load @0x13 signed, then half load @0x12 unsigned -> rdata=0xFFFFFFDE, then rdata=0x0000DE7F.
REQ-037 Half load @0x11, word store @0x16, and word load @(4*DEPTH_WORDS) -> each gives err=1 and rdata=0; word @0x14 is unchanged.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and data stable, req_ready=0, then return to IDLE one cycle after resp_ready=1.
REQ-039 Assert rst during WAIT after a store of 0x12345678 @0x20 -> no response; req_ready=1 on the first cycle after rst deasserts; a subsequent load @0x20 returns 0x12345678.
REQ-040 Repeat REQ-035 with LATENCY=1 and LATENCY=15 -> response latency equals LATENCY exactly.
